// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared state type, neighbour bit positions and uniform-code helper for the LBP engine
package lbp_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    // Bit position of each neighbour in the raw 8-bit code
    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    // Neighbours visited clockwise around the centre, starting top-left
    localparam int RING [8] = '{NB_TL, NB_T, NB_TR, NB_R, NB_BR, NB_B, NB_BL, NB_L};

    function automatic logic [7:0] uniform_code(input logic [7:0] bits);
        int trans;
        int ones;
        trans = 0;
        ones  = 0;
        for (int i = 0; i < 8; i++) begin
            if (bits[3'(RING[i])] != bits[3'(RING[(i + 1) % 8])]) trans++;
            if (bits[3'(i)]) ones++;
        end
        return (trans <= 2) ? 8'(ones) : 8'd9;
    endfunction

endpackage

// File: rtl/lbp_stream_engine_if.sv
// rtl/lbp_stream_engine_if.sv - gray-pixel read bus and LBP-code write bus of the LBP engine
interface lbp_stream_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
);
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;

    modport master (
        input  gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp_line_buf.sv
// rtl/lbp_line_buf.sv - one-row delay line; returns the entry about to be overwritten on each enabled cycle
module lbp_line_buf #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            mem[ptr] <= din;
            ptr      <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end
endmodule

// File: rtl/lbp_stream_engine.sv
// rtl/lbp_stream_engine.sv - streaming 3x3 LBP engine; define LBP_UNIFORM_EN for uniform (0..9) codes
module lbp_stream_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input logic                 clk,
    input logic                 reset,
    lbp_stream_engine_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_K     = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] FIRST_WR_K = ADDR_W'(IMG_W + 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] wr_cnt;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              capture, stream_wr, flush_wr, interior;
    logic [DATA_W-1:0] lb1_out, lb2_out, center;
    logic [DATA_W-1:0] top_w [2];
    logic [DATA_W-1:0] mid_w [2];
    logic [DATA_W-1:0] bot_w [2];
    logic [DATA_W-1:0] nb [8];
    logic [7:0]        raw_code, code;
    logic              lbp_valid_q, finish_q;
    logic [ADDR_W-1:0] lbp_addr_q;
    logic [7:0]        lbp_data_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        flush_wr = 1'b0;
        case (state)
            IDLE:   state_nx = STREAM;
            STREAM: begin
                capture = bus.gray_ready;
                if (capture && k == LAST_K) state_nx = FLUSH;
            end
            FLUSH: begin
                flush_wr = 1'b1;
                if (wr_cnt == LAST_K) state_nx = DONE;
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture of (row,col) completes the window centred on (row-1,col-1)
    assign stream_wr = capture && (k >= FIRST_WR_K);
    assign interior  = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            k   <= '0;
            row <= '0;
            col <= '0;
        end else if (capture) begin
            k <= k + 1'b1;
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    lbp_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk(clk), .reset(reset), .en(capture), .din(bus.gray_data), .dout(lb1_out)
    );

    lbp_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb2 (
        .clk(clk), .reset(reset), .en(capture), .din(lb1_out), .dout(lb2_out)
    );

    // Index 0 holds column col-2, index 1 holds column col-1 of each window row
    always_ff @(posedge clk) begin
        if (capture) begin
            top_w[0] <= top_w[1];
            top_w[1] <= lb2_out;
            mid_w[0] <= mid_w[1];
            mid_w[1] <= lb1_out;
            bot_w[0] <= bot_w[1];
            bot_w[1] <= bus.gray_data;
        end
    end

    assign nb[NB_TL] = top_w[0];
    assign nb[NB_T]  = top_w[1];
    assign nb[NB_TR] = lb2_out;
    assign nb[NB_L]  = mid_w[0];
    assign nb[NB_R]  = lb1_out;
    assign nb[NB_BL] = bot_w[0];
    assign nb[NB_B]  = bot_w[1];
    assign nb[NB_BR] = bus.gray_data;
    assign center    = mid_w[1];

    always_comb begin
        raw_code = '0;
        for (int i = 0; i < 8; i++) begin
            raw_code[3'(i)] = (nb[3'(i)] >= center);
        end
`ifdef LBP_UNIFORM_EN
        code = uniform_code(raw_code);
`else
        code = raw_code;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            finish_q    <= 1'b0;
            wr_cnt      <= '0;
        end else begin
            lbp_valid_q <= stream_wr || flush_wr;
            if (stream_wr || flush_wr) begin
                lbp_addr_q <= wr_cnt;
                lbp_data_q <= (stream_wr && interior) ? code : 8'd0;
                wr_cnt     <= wr_cnt + 1'b1;
            end
            if (state == DONE) finish_q <= 1'b1;
        end
    end

    assign bus.gray_req  = capture;
    assign bus.gray_addr = k;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.finish    = finish_q;
endmodule
